// File: rtl/dma_periph_requester.sv
// Peripheral end of a single 8237A DMA channel: byte FIFO fed by device logic,
// registered DREQ, DACK/IOR_N read-out onto the data bus, EOP_N termination.
module dma_periph_requester #(
  parameter int DEPTH        = 16,
  parameter int THRESH       = 1,
  parameter int DREQ_ACT_LOW = 0,
  parameter int DACK_ACT_LOW = 1
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       enable,
  input  logic                       demand_mode,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       DREQ,
  input  logic                       DACK,
  input  logic                       IOR_N,
  input  logic                       EOP_N,
  output logic [7:0]                 DB_OUT,
  output logic                       DB_OE,
  output logic                       tc_done,
  input  logic                       clear_tc,
  output logic                       ovf,
  output logic                       unf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] THR  = CW'(THRESH);
  localparam logic [CW-1:0] FULLC = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, XFER, RELEASE} state_t;

  state_t state, stateNext;
  logic dreqQ, dreqNext, modeQ, modeNext, tcSet;
  logic dack, eop, iorPrev, strobe, pop, wrEn;
  logic [AW-1:0] rdPtr, wrPtr;
  logic [CW-1:0] countNext;
  logic [7:0] mem [DEPTH];

  assign dack      = (DACK_ACT_LOW != 0) ? ~DACK : DACK;
  assign eop       = ~EOP_N;
  assign strobe    = dack & ~iorPrev & IOR_N;
  assign pop       = strobe & (count != '0);
  // a pop frees the head slot in the same edge, so a full FIFO can still accept
  assign wrEn      = push & (~full | pop);
  assign countNext = count + CW'(wrEn) - CW'(pop);
  assign full      = (count == FULLC);
  assign DREQ      = dreqQ ^ (DREQ_ACT_LOW != 0);

  // bus is only driven during an acknowledged read; idle bus value is 0
  assign DB_OE  = ~RESET & dack & ~IOR_N;
  assign DB_OUT = DB_OE ? ((count == '0) ? 8'hFF : mem[rdPtr]) : 8'h00;

  always_ff @(posedge CLK) begin
    if (wrEn) mem[wrPtr] <= push_data;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rdPtr   <= '0;
      wrPtr   <= '0;
      count   <= '0;
      iorPrev <= 1'b1;
      ovf     <= 1'b0;
      unf     <= 1'b0;
      tc_done <= 1'b0;
    end else begin
      iorPrev <= IOR_N;
      count   <= countNext;
      if (wrEn) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      if (push & full & ~pop)     ovf <= 1'b1;
      if (strobe & (count == '0)) unf <= 1'b1;
      if (tcSet)         tc_done <= 1'b1;
      else if (clear_tc) tc_done <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      dreqQ <= 1'b0;
      modeQ <= 1'b0;
    end else begin
      state <= stateNext;
      dreqQ <= dreqNext;
      modeQ <= modeNext;
    end
  end

  always_comb begin
    stateNext = state;
    dreqNext  = 1'b0;
    modeNext  = modeQ;
    tcSet     = 1'b0;
    case (state)
      IDLE: begin
        if (enable & ~tc_done & (count >= THR)) begin
          stateNext = REQ;
          modeNext  = demand_mode;
        end
      end
      REQ: begin
        if (~enable) stateNext = IDLE;
        else if (dack) begin
          stateNext = XFER;
          dreqNext  = modeQ;
        end else dreqNext = 1'b1;
      end
      XFER: begin
        dreqNext = modeQ & (countNext != '0);
        if (eop) begin
          dreqNext  = 1'b0;
          tcSet     = 1'b1;
          stateNext = RELEASE;
        end else if (strobe) begin
          if (~modeQ | (countNext == '0)) stateNext = RELEASE;
        end else if (~dack) stateNext = RELEASE;
      end
      RELEASE: begin
        if (~dack) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dma_periph_requester.sv
// Directed bench for dma_periph_requester: one active-high instance driven from a
// vector table plus hand sequences, and one inverted-polarity instance.
module tb_dma_periph_requester;
  logic CLK, RESET;
  logic enable, demand_mode, push, DACK, IOR_N, EOP_N, clear_tc;
  logic [7:0] push_data, DB_OUT;
  logic full, DREQ, DB_OE, tc_done, ovf, unf;
  logic [4:0] count;

  logic enable1, demand1, push1, DACK1, IOR1, EOP1, clr1;
  logic [7:0] pd1, DB_OUT1;
  logic full1, DREQ1, DB_OE1, tc1, ovf1, unf1;
  logic [4:0] count1;

  int nVec = 0;
  int nBad = 0;

  dma_periph_requester #(.DEPTH(16), .THRESH(1), .DREQ_ACT_LOW(0), .DACK_ACT_LOW(0)) u0 (
    .CLK(CLK), .RESET(RESET), .enable(enable), .demand_mode(demand_mode), .push(push),
    .push_data(push_data), .full(full), .count(count), .DREQ(DREQ), .DACK(DACK),
    .IOR_N(IOR_N), .EOP_N(EOP_N), .DB_OUT(DB_OUT), .DB_OE(DB_OE), .tc_done(tc_done),
    .clear_tc(clear_tc), .ovf(ovf), .unf(unf));

  dma_periph_requester #(.DEPTH(16), .THRESH(1), .DREQ_ACT_LOW(1), .DACK_ACT_LOW(1)) u1 (
    .CLK(CLK), .RESET(RESET), .enable(enable1), .demand_mode(demand1), .push(push1),
    .push_data(pd1), .full(full1), .count(count1), .DREQ(DREQ1), .DACK(DACK1),
    .IOR_N(IOR1), .EOP_N(EOP1), .DB_OUT(DB_OUT1), .DB_OE(DB_OE1), .tc_done(tc1),
    .clear_tc(clr1), .ovf(ovf1), .unf(unf1));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, expected to finish");
    $fatal(1);
  end

  typedef struct {
    logic dm, psh;
    logic [7:0] pd;
    logic dack, ior;
    logic dreq;
    logic [4:0] cnt;
    logic oe;
    logic [7:0] dout;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic dm, logic psh, logic [7:0] pd, logic dk, logic io,
                              logic dr, logic [4:0] c, logic oe, logic [7:0] d);
    vec_t v;
    v.dm = dm; v.psh = psh; v.pd = pd; v.dack = dk; v.ior = io;
    v.dreq = dr; v.cnt = c; v.oe = oe; v.dout = d;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic doReset();
    #2 RESET = 1'b1;
    #2 RESET = 1'b0;
  endtask

  initial begin
    bit seen;
    RESET = 1'b1;
    enable = 1'b1; demand_mode = 1'b0; push = 1'b0; push_data = 8'h00;
    DACK = 1'b0; IOR_N = 1'b1; EOP_N = 1'b1; clear_tc = 1'b0;
    enable1 = 1'b1; demand1 = 1'b1; push1 = 1'b0; pd1 = 8'h00;
    DACK1 = 1'b1; IOR1 = 1'b1; EOP1 = 1'b1; clr1 = 1'b0;
    #12;
    chk("rst_dreq", DREQ, 0);
    chk("rst_count", count, 0);
    chk("rst_oe", DB_OE, 0);
    chk("rst_dbout", DB_OUT, 0);
    chk("rst_flags", {tc_done, ovf, unf}, 0);
    chk("rst_dreq_actlow", DREQ1, 1);
    @(negedge CLK) RESET = 1'b0;
    @(posedge CLK); #1;

    // first-request latency, single mode drains, demand mode streams
    tbl.push_back(mk(0,1,8'hA5,0,1, 0,1,0,8'h00));
    tbl.push_back(mk(0,0,8'h00,0,1, 0,1,0,8'h00));
    tbl.push_back(mk(0,0,8'h00,0,1, 1,1,0,8'h00));
    tbl.push_back(mk(0,0,8'h00,1,1, 0,1,0,8'h00));
    tbl.push_back(mk(0,0,8'h00,1,0, 0,1,1,8'hA5));
    tbl.push_back(mk(0,0,8'h00,1,1, 0,0,0,8'h00));
    tbl.push_back(mk(0,0,8'h00,0,1, 0,0,0,8'h00));
    tbl.push_back(mk(0,0,8'h00,0,1, 0,0,0,8'h00));
    tbl.push_back(mk(0,1,8'hA1,0,1, 0,1,0,8'h00));
    tbl.push_back(mk(0,1,8'hA2,0,1, 0,2,0,8'h00));
    tbl.push_back(mk(0,0,8'h00,0,1, 1,2,0,8'h00));
    tbl.push_back(mk(0,0,8'h00,1,1, 0,2,0,8'h00));
    tbl.push_back(mk(0,0,8'h00,1,0, 0,2,1,8'hA1));
    tbl.push_back(mk(0,0,8'h00,1,1, 0,1,0,8'h00));
    tbl.push_back(mk(0,0,8'h00,0,1, 0,1,0,8'h00));
    tbl.push_back(mk(0,0,8'h00,0,1, 0,1,0,8'h00));
    tbl.push_back(mk(0,0,8'h00,0,1, 1,1,0,8'h00));
    tbl.push_back(mk(0,0,8'h00,1,1, 0,1,0,8'h00));
    tbl.push_back(mk(0,0,8'h00,1,0, 0,1,1,8'hA2));
    tbl.push_back(mk(0,0,8'h00,1,1, 0,0,0,8'h00));
    tbl.push_back(mk(0,0,8'h00,0,1, 0,0,0,8'h00));
    tbl.push_back(mk(1,1,8'hB0,0,1, 0,1,0,8'h00));
    tbl.push_back(mk(1,1,8'hB1,0,1, 0,2,0,8'h00));
    tbl.push_back(mk(1,1,8'hB2,0,1, 1,3,0,8'h00));
    tbl.push_back(mk(1,1,8'hB3,0,1, 1,4,0,8'h00));
    tbl.push_back(mk(1,0,8'h00,1,1, 1,4,0,8'h00));
    tbl.push_back(mk(1,0,8'h00,1,0, 1,4,1,8'hB0));
    tbl.push_back(mk(1,0,8'h00,1,1, 1,3,0,8'h00));
    tbl.push_back(mk(1,0,8'h00,1,0, 1,3,1,8'hB1));
    tbl.push_back(mk(1,0,8'h00,1,1, 1,2,0,8'h00));
    tbl.push_back(mk(1,0,8'h00,1,0, 1,2,1,8'hB2));
    tbl.push_back(mk(1,0,8'h00,1,1, 1,1,0,8'h00));
    tbl.push_back(mk(1,0,8'h00,1,0, 1,1,1,8'hB3));
    tbl.push_back(mk(1,0,8'h00,1,1, 0,0,0,8'h00));
    tbl.push_back(mk(1,0,8'h00,0,1, 0,0,0,8'h00));

    foreach (tbl[i]) begin
      demand_mode = tbl[i].dm; push = tbl[i].psh; push_data = tbl[i].pd;
      DACK = tbl[i].dack; IOR_N = tbl[i].ior;
      step();
      chk($sformatf("v%0d_dreq", i), DREQ, tbl[i].dreq);
      chk($sformatf("v%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("v%0d_oe", i), DB_OE, tbl[i].oe);
      if (tbl[i].oe) chk($sformatf("v%0d_dbout", i), DB_OUT, tbl[i].dout);
      chk($sformatf("v%0d_flags", i), {tc_done, ovf, unf}, 0);
    end
    push = 1'b0; DACK = 1'b0; IOR_N = 1'b1;

    // EOP termination, clear/set race, tc_done blocking
    EOP_N = 1'b0; step(); EOP_N = 1'b1;
    chk("eop_idle_ignored", tc_done, 0);
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; push_data = 8'hC0 + 8'(i); step();
    end
    push = 1'b0;
    seen = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      if (DREQ) seen = 1; else step();
    end
    chk("t4_dreq_wait", seen, 1);
    DACK = 1'b1; step();
    IOR_N = 1'b0; step(); chk("t4_dout0", DB_OUT, 8'hC0);
    IOR_N = 1'b1; step(); chk("t4_cnt1", count, 3); chk("t4_dreq1", DREQ, 1);
    IOR_N = 1'b0; step(); chk("t4_dout1", DB_OUT, 8'hC1);
    IOR_N = 1'b1; EOP_N = 1'b0; clear_tc = 1'b1; step();
    EOP_N = 1'b1; clear_tc = 1'b0;
    chk("t4_cnt2", count, 2);
    chk("t4_tc", tc_done, 1);
    chk("t4_dreq_drop", DREQ, 0);
    DACK = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("t4_blocked", DREQ, 0);
    chk("t4_tc_hold", tc_done, 1);
    clear_tc = 1'b1; step(); clear_tc = 1'b0;
    chk("t4_tc_clr", tc_done, 0);
    seen = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      step();
      if (DREQ) seen = 1;
    end
    chk("t4_rerequest", seen, 1);

    // overflow, full push+pop, underflow
    doReset();
    chk("t5_rst_count", count, 0);
    enable = 1'b0; demand_mode = 1'b0;
    for (int i = 0; i < 16; i++) begin
      push = 1'b1; push_data = 8'hD0 + 8'(i); step();
    end
    chk("t5_count_full", count, 16);
    chk("t5_full", full, 1);
    chk("t5_ovf0", ovf, 0);
    push_data = 8'hEE; step();
    chk("t5_ovf", ovf, 1);
    chk("t5_count_ovf", count, 16);
    push = 1'b0; DACK = 1'b1; step();
    chk("t5_oe_iorhigh", DB_OE, 0);
    IOR_N = 1'b0; step(); chk("t5_head", DB_OUT, 8'hD0);
    IOR_N = 1'b1; push = 1'b1; push_data = 8'hE0; step(); push = 1'b0;
    chk("t5_pushpop_full", count, 16);
    for (int i = 0; i < 16; i++) begin
      IOR_N = 1'b0; step();
      chk($sformatf("t5_drain%0d", i), DB_OUT, (i < 15) ? 8'hD1 + 8'(i) : 8'hE0);
      IOR_N = 1'b1; step();
    end
    chk("t5_empty", count, 0);
    chk("t5_unf0", unf, 0);
    IOR_N = 1'b0; step();
    chk("t5_oe_empty", DB_OE, 1);
    chk("t5_ff", DB_OUT, 8'hFF);
    IOR_N = 1'b1; step();
    chk("t5_unf", unf, 1);
    chk("t5_count_unf", count, 0);
    DACK = 1'b0;

    // inverted polarities, reset mid-transfer
    doReset();
    chk("t6_idle_dreq", DREQ1, 1);
    push1 = 1'b1; pd1 = 8'h5A; step();
    pd1 = 8'h5B; step();
    chk("t6_dreq_lat", DREQ1, 1);
    push1 = 1'b0; step();
    chk("t6_dreq_act", DREQ1, 0);
    DACK1 = 1'b0; step();
    chk("t6_xfer_dreq", DREQ1, 0);
    IOR1 = 1'b0; step();
    chk("t6_oe", DB_OE1, 1);
    chk("t6_dout", DB_OUT1, 8'h5A);
    #2 RESET = 1'b1;
    #1;
    chk("t6_rst_dreq", DREQ1, 1);
    chk("t6_rst_count", count1, 0);
    chk("t6_rst_oe", DB_OE1, 0);
    #2 RESET = 1'b0;
    DACK1 = 1'b1; IOR1 = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end
endmodule
